// File: rtl/div_radix2.sv
// Iterative radix-2 restoring divider (DIV/DIVU): WIDTH iterations, valid/ready in and out.
// Optional macro DIV_CANCEL_EN adds a cancel input that flushes an in-flight division.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic             busy
`ifdef DIV_CANCEL_EN
    ,
    input  logic             cancel
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] dvs_mag_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] out_quot_q;
    logic [WIDTH-1:0] out_rem_q;
    logic             signed_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             dz_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             cancel_req;
    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_trial;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

`ifdef DIV_CANCEL_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    assign dvd_neg = signed_q & dividend_q[WIDTH-1];
    assign dvs_neg = signed_q & divisor_q[WIDTH-1];

    // The restored remainder is always below |divisor|, so WIDTH bits hold it;
    // only the shifted value and the trial difference need the extra bit.
    assign rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign rem_trial = rem_shift - {1'b0, dvs_mag_q};

    assign quot_fix = dz_q ? {WIDTH{1'b1}} : (qneg_q ? -quot_q : quot_q);
    assign rem_fix  = dz_q ? dividend_q    : (rneg_q ? -rem_q  : rem_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dividend_q  <= '0;
            divisor_q   <= '0;
            dvs_mag_q   <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            out_quot_q  <= '0;
            out_rem_q   <= '0;
            signed_q    <= 1'b0;
            qneg_q      <= 1'b0;
            rneg_q      <= 1'b0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (cancel_req && (state_q != S_IDLE)) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        dividend_q <= in_dividend;
                        divisor_q  <= in_divisor;
                        signed_q   <= in_signed;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= S_PREP;
                    end
                end
                S_PREP: begin
                    quot_q    <= dvd_neg ? -dividend_q : dividend_q;
                    dvs_mag_q <= dvs_neg ? -divisor_q  : divisor_q;
                    qneg_q    <= dvd_neg ^ dvs_neg;
                    rneg_q    <= dvd_neg;
                    dz_q      <= (divisor_q == '0);
                    rem_q     <= '0;
                    cnt_q     <= '0;
                    state_q   <= S_ITER;
                end
                S_ITER: begin
                    if (!rem_trial[WIDTH]) begin
                        rem_q  <= rem_trial[WIDTH-1:0];
                        quot_q <= {quot_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_q  <= rem_shift[WIDTH-1:0];
                        quot_q <= {quot_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    out_quot_q  <= quot_fix;
                    out_rem_q   <= rem_fix;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_quot  = out_quot_q;
    assign out_rem   = out_rem_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_div_radix2.sv
// Directed plus randomized bench for div_radix2 (WIDTH=32) against an arithmetic reference.
module tb_div_radix2;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic          clk = 1'b0;
    logic          resetn;
    logic          in_valid;
    logic          in_ready;
    logic          in_signed;
    logic [W-1:0]  in_dividend;
    logic [W-1:0]  in_divisor;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_quot;
    logic [W-1:0]  out_rem;
    logic          busy;
`ifdef DIV_CANCEL_EN
    logic          cancel;
`endif

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    div_radix2 #(.WIDTH(W)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_rem     (out_rem),
        .busy        (busy)
`ifdef DIV_CANCEL_EN
        ,
        .cancel      (cancel)
`endif
    );

    always #5 clk = ~clk;

    // Reference: truncating division, remainder takes the dividend's sign.
    function automatic void model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa;
        longint sb;
        if (b == '0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with the divider idle; the request is accepted on the next edge.
    task automatic issue(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid    = 1'b1;
        in_signed   = s;
        in_dividend = a;
        in_divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic collect(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int n;
        model(s, a, b, eq, er);
        @(posedge clk);
        #1;
        n = 1;
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'(LAT));
        chk({tag, "_quot"}, {32'd0, out_quot}, {32'd0, eq});
        chk({tag, "_rem"}, {32'd0, out_rem}, {32'd0, er});
        if (out_ready) begin
            @(posedge clk);
            #1;
            chk({tag, "_idle"}, {62'd0, in_ready, out_valid}, 64'd2);
        end
    endtask

    task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        issue(s, a, b, tag);
        collect(s, a, b, tag);
        $display("op %s signed=%0d a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h", tag, s, a, b, out_quot, out_rem);
    endtask

    initial begin
        logic [W-1:0] hq;
        logic [W-1:0] hr;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        bit           rs;
        bit           seen;

        resetn      = 1'b0;
        in_valid    = 1'b0;
        in_signed   = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b1;
`ifdef DIV_CANCEL_EN
        cancel      = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {59'd0, in_ready, out_valid, busy, out_quot == '0, out_rem == '0},
            {59'd0, 5'b10011});
        resetn = 1'b1;
        @(posedge clk);
        #1;

        run_op(1'b0, 32'd100, 32'd7, "divu_100_7");
        run_op(1'b1, -32'sd7, 32'd2, "div_m7_2");
        run_op(1'b1, 32'd7, -32'sd2, "div_7_m2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "divu_ovf_ops");
        run_op(1'b1, -32'sd5, 32'd0, "div_m5_0");
        run_op(1'b0, 32'd9, 32'd0, "divu_9_0");
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");

        // Result held in DONE while the consumer stalls; a new request waits.
        out_ready = 1'b0;
        issue(1'b1, -32'sd100, 32'd7, "hold");
        collect(1'b1, -32'sd100, 32'd7, "hold");
        hq = out_quot;
        hr = out_rem;
        in_valid    = 1'b1;
        in_signed   = 1'b0;
        in_dividend = 32'd100;
        in_divisor  = 32'd7;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("hold_stable", {30'd0, out_valid, in_ready, out_quot, out_rem == hr},
                {30'd0, 2'b10, hq, 1'b1});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release_ready", {62'd0, in_ready, out_valid}, 64'd2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        collect(1'b0, 32'd100, 32'd7, "after_hold");

        // Asynchronous reset in the middle of the iterations.
        issue(1'b0, 32'd100, 32'd7, "mid_reset");
        repeat (12) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_reset_outputs", {59'd0, in_ready, out_valid, busy, out_quot == '0, out_rem == '0},
            {59'd0, 5'b10011});
        @(posedge clk);
        #1;
        resetn = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        chk("mid_reset_no_result", {63'd0, seen}, 64'd0);
        run_op(1'b0, 32'd100, 32'd7, "after_reset");

`ifdef DIV_CANCEL_EN
        issue(1'b0, 32'd100, 32'd7, "cancel");
        repeat (12) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        chk("cancel_idle", {61'd0, in_ready, out_valid, busy}, 64'd4);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= out_valid;
        end
        chk("cancel_no_result", {63'd0, seen}, 64'd0);
        run_op(1'b0, 32'd100, 32'd7, "after_cancel");
`endif

        for (int i = 0; i < 40; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 4))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = -32'($urandom_range(1, 300));
                default: rb = 32'($urandom);
            endcase
            run_op(rs, ra, rb, "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
